// File: rtl/cart_select_ctrl.sv
// cart_select_ctrl: cartridge selection and load sequencer between the board
// buttons, the main_mem flash loader and the NES core.
// Compile-time option: define CART_DEBOUNCE_EN to include the button debounce
// counter; when it is undefined the synchronised buttons are used directly.
module cart_select_ctrl #(
   parameter int DEBOUNCE_W   = 16,
   parameter int CE_DIV       = 4,
   parameter int DROP_TIMEOUT = 255
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] buttons,
   input  logic       load_done,
   output logic       reload,
   output logic [3:0] index,
   output logic       nes_reset,
   output logic       nes_ce,
   output logic       busy
);

   localparam int              TW        = (DROP_TIMEOUT < 1) ? 1 : $clog2(DROP_TIMEOUT + 1);
   localparam logic [3:0]      CE_LAST   = 4'(CE_DIV - 1);
   localparam logic [TW-1:0]   DROP_LAST = TW'(DROP_TIMEOUT);

   typedef enum logic [2:0] {
      WAIT_LOAD,
      RUN,
      HELD,
      RELOAD,
      WAIT_DROP
   } state_t;

   // Reject parameter values the counters cannot represent.
   if (CE_DIV < 2 || CE_DIV > 16 || DEBOUNCE_W < 1) begin : g_bad_param
      $error("cart_select_ctrl: CE_DIV must be 2..16 and DEBOUNCE_W at least 1");
   end

   logic [4:0]    sync_meta;
   logic [4:0]    sync;
   logic [4:0]    stable;
   logic [1:0]    slot;
   logic [3:0]    ce_cnt;
   logic [TW-1:0] drop_cnt;
   state_t        state;
   state_t        state_next;

   // Two-flop synchroniser; idle (released) buttons read as ones.
   // NOTE: every clocked block uses non-blocking assignments so all registers
   // sample their inputs from the same edge regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_meta <= '1;
         sync      <= '1;
      end else begin
         sync_meta <= buttons;
         sync      <= sync_meta;
      end
   end

`ifdef CART_DEBOUNCE_EN
   logic [4:0]            sync_prev;
   logic [DEBOUNCE_W-1:0] db_cnt;

   // Shared debounce counter: restarts whenever the synchronised inputs move
   // and saturates; stable only follows sync after a full quiet interval.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_prev <= '1;
         db_cnt    <= '0;
         stable    <= '1;
      end else begin
         sync_prev <= sync;
         if (sync != sync_prev) begin
            db_cnt <= '0;
         end else if (db_cnt != '1) begin
            db_cnt <= db_cnt + 1'b1;
         end
         if (sync == sync_prev && db_cnt == '1) begin
            stable <= sync;
         end
      end
   end
`else
   assign stable = sync;
`endif

   // Lowest-numbered pressed slot wins when several are held together.
   always_comb begin
      if (!stable[0]) begin
         slot = 2'd0;
      end else if (!stable[1]) begin
         slot = 2'd1;
      end else if (!stable[2]) begin
         slot = 2'd2;
      end else begin
         slot = 2'd3;
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= WAIT_LOAD;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and Moore output decode.
   // NOTE: every output is given a default before the case so no path leaves
   // a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      reload     = 1'b0;
      nes_reset  = 1'b1;
      busy       = 1'b1;
      case (state)
         WAIT_LOAD: begin
            if (load_done) state_next = RUN;
         end
         RUN: begin
            nes_reset = 1'b0;
            busy      = 1'b0;
            if (stable[3:0] != 4'b1111) state_next = HELD;
         end
         HELD: begin
            nes_reset = 1'b0;
            busy      = 1'b0;
            if (stable[3:0] == 4'b1111) state_next = RELOAD;
         end
         RELOAD: begin
            reload     = 1'b1;
            state_next = WAIT_DROP;
         end
         WAIT_DROP: begin
            if (!load_done || drop_cnt == DROP_LAST) state_next = WAIT_LOAD;
         end
         default: state_next = WAIT_LOAD;
      endcase
   end

   // Bounds the wait for main_mem to acknowledge the reload by dropping load_done.
   always_ff @(posedge clock) begin
      if (reset || state != WAIT_DROP) begin
         drop_cnt <= '0;
      end else if (drop_cnt != DROP_LAST) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

   // ROM index follows the held buttons only while in HELD; frozen elsewhere.
   always_ff @(posedge clock) begin
      if (reset) begin
         index <= '0;
      end else if (state == HELD && stable[3:0] != 4'b1111) begin
         index <= {1'b0, ~stable[4], slot};
      end
   end

   // Free-running NES clock-enable divider; independent of the FSM.
   always_ff @(posedge clock) begin
      if (reset) begin
         ce_cnt <= '0;
      end else if (ce_cnt == CE_LAST) begin
         ce_cnt <= '0;
      end else begin
         ce_cnt <= ce_cnt + 1'b1;
      end
   end

   assign nes_ce = (ce_cnt == CE_LAST);

endmodule

// File: tb/tb_cart_select_ctrl.sv
// Self-checking bench for cart_select_ctrl (DEBOUNCE_W=4, CE_DIV=4).
module tb_cart_select_ctrl;

   localparam int DW  = 4;
   localparam int CED = 4;
`ifdef CART_DEBOUNCE_EN
   localparam int LAT = 2 + (1 << DW) + 1;
`else
   localparam int LAT = 2;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] buttons;
   logic       load_done;
   logic       reload;
   logic [3:0] index;
   logic       nes_reset;
   logic       nes_ce;
   logic       busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0] btn;
      logic [3:0] idx;
      string      name;
   } sel_vec_t;

   sel_vec_t vecs[6];

   cart_select_ctrl #(
      .DEBOUNCE_W  (DW),
      .CE_DIV      (CED),
      .DROP_TIMEOUT(255)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .buttons  (buttons),
      .load_done(load_done),
      .reload   (reload),
      .index    (index),
      .nes_reset(nes_reset),
      .nes_ce   (nes_ce),
      .busy     (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Press a pattern long enough to debounce, release, then wait for reload.
   task automatic select(input logic [4:0] btn, input string name, output int n);
      buttons = btn;
      step(40);
      check({name, "_held_run"}, {busy, nes_reset}, 2'b00);
      buttons = 5'b11111;
      n = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clock);
         if (reload) begin
            n = i;
            break;
         end
      end
      check({name, "_reload_latency"}, n, LAT + 1);
   endtask

   initial begin
      int n;
      int cnt_rel;
      int cnt_busy;

      vecs[0] = '{5'b11110, 4'b0000, "slot0"};
      vecs[1] = '{5'b01101, 4'b0101, "slot1_shift"};
      vecs[2] = '{5'b10110, 4'b0000, "prio_3_0"};
      vecs[3] = '{5'b11011, 4'b0010, "slot2"};
      vecs[4] = '{5'b00000, 4'b0100, "all_shift"};
      vecs[5] = '{5'b00111, 4'b0111, "slot3_shift"};

      // Reset values.
      reset     = 1'b1;
      load_done = 1'b0;
      buttons   = 5'b11111;
      step(3);
      check("rst_index", index, 4'h0);
      check("rst_reload", reload, 1'b0);
      check("rst_nes_reset", nes_reset, 1'b1);
      check("rst_busy", busy, 1'b1);
      check("rst_nes_ce", nes_ce, 1'b0);

      // Reset then load: load_done rises at cycle 50, nes_ce at 3, 7, 11, ...
      reset = 1'b0;
      for (int c = 0; c <= 60; c++) begin
         check($sformatf("ce_c%0d", c), nes_ce, (c % CED) == (CED - 1));
         if (c <= 50) check($sformatf("nes_reset_c%0d", c), nes_reset, 1'b1);
         if (c == 51) check("nes_reset_fall", {nes_reset, busy}, 2'b00);
         if (c == 50) load_done = 1'b1;
         step(1);
      end

      // Table of selections, each followed by a full reload handshake.
      for (int v = 0; v < 6; v++) begin
         select(vecs[v].btn, vecs[v].name, n);
         check({vecs[v].name, "_index"}, index, vecs[v].idx);
         check({vecs[v].name, "_reload_nes_reset"}, {nes_reset, busy}, 2'b11);
         step(1);
         check({vecs[v].name, "_reload_one_cycle"}, reload, 1'b0);
         check({vecs[v].name, "_drop_nes_reset"}, nes_reset, 1'b1);
         load_done = 1'b0;
         cnt_rel = 0;
         for (int i = 0; i < 5; i++) begin
            step(1);
            cnt_rel += int'(reload);
         end
         check({vecs[v].name, "_no_extra_reload"}, cnt_rel, 0);
         check({vecs[v].name, "_wait_load"}, {nes_reset, busy}, 2'b11);
         load_done = 1'b1;
         step(1);
         check({vecs[v].name, "_run"}, {nes_reset, busy}, 2'b00);
         check({vecs[v].name, "_index_kept"}, index, vecs[v].idx);
      end

`ifdef CART_DEBOUNCE_EN
      // Bounce rejection: buttons[2] toggles every 5 cycles for 100 cycles.
      cnt_rel  = 0;
      cnt_busy = 0;
      for (int t = 0; t < 20; t++) begin
         buttons = (t % 2 == 0) ? 5'b11011 : 5'b11111;
         for (int i = 0; i < 5; i++) begin
            step(1);
            cnt_rel  += int'(reload);
            cnt_busy += int'(busy);
         end
      end
      buttons = 5'b11111;
      for (int i = 0; i < 40; i++) begin
         step(1);
         cnt_rel  += int'(reload);
         cnt_busy += int'(busy);
      end
      check("bounce_no_reload", cnt_rel, 0);
      check("bounce_no_busy", cnt_busy, 0);
      check("bounce_index", index, 4'b0111);
`endif

      // Timeout: load_done stays high, WAIT_DROP lasts 256 cycles.
      select(5'b11101, "timeout", n);
      check("timeout_index", index, 4'b0001);
      n = 0;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clock);
         if (!busy) begin
            n = i;
            break;
         end
      end
      check("timeout_to_run", n, 258);
      check("timeout_nes_reset", nes_reset, 1'b0);

      // Reset asserted during the RELOAD cycle.
      select(5'b10111, "rst_mid", n);
      check("rst_mid_in_reload", reload, 1'b1);
      reset = 1'b1;
      step(1);
      check("rst_mid_reload", reload, 1'b0);
      check("rst_mid_index", index, 4'h0);
      check("rst_mid_state", {nes_reset, busy}, 2'b11);
      reset = 1'b0;
      cnt_rel = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         cnt_rel += int'(reload);
      end
      check("rst_mid_no_reload", cnt_rel, 0);
      check("rst_mid_run", {nes_reset, busy}, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
